// File: rtl/axi_lite_arbiter2_pkg.sv
// Shared AXI4-Lite response codes and arbiter FSM states for axi_lite_arbiter2.
package axi_lite_arbiter2_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RA,
    RD,
    WA,
    WB
  } state_t;

endpackage

// File: rtl/axi_lite_arbiter2_rr.sv
// Two-way request picker: round-robin on last owner, or m1-wins when fixed is set.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixed || !last) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/axi_lite_arbiter2.sv
// Shares one AXI4-Lite slave between IFU (m0) and LSU (m1), one transaction at a time.
module axi_lite_arbiter2
  import axi_lite_arbiter2_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   m0_araddr,
  input  logic            m0_arvalid,
  output logic            m0_arready,
  output logic [DW-1:0]   m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  input  logic [AW-1:0]   m0_awaddr,
  input  logic            m0_awvalid,
  output logic            m0_awready,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic            m0_wvalid,
  output logic            m0_wready,
  output logic [1:0]      m0_bresp,
  output logic            m0_bvalid,
  input  logic            m0_bready,
  input  logic [AW-1:0]   m1_araddr,
  input  logic            m1_arvalid,
  output logic            m1_arready,
  output logic [DW-1:0]   m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  input  logic [AW-1:0]   m1_awaddr,
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  output logic [1:0]      m1_bresp,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  output logic [AW-1:0]   s_araddr,
  output logic            s_arvalid,
  input  logic            s_arready,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic            s_rvalid,
  output logic            s_rready,
  output logic [AW-1:0]   s_awaddr,
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  output logic            s_wvalid,
  input  logic            s_wready,
  input  logic [1:0]      s_bresp,
  input  logic            s_bvalid,
  output logic            s_bready,
  output logic [1:0]      grant,
  output logic            busy
);

  state_t     state;
  logic [1:0] grant_q;
  logic       last;
  logic       aw_done;
  logic       w_done;
  logic [1:0] req;
  logic [1:0] pick;
  logic       sel;
  logic       in_ra, in_rd, in_wa, in_wb;
  logic       aw_hs, w_hs;

  assign req = {m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid};

  rr_arbiter2 u_pick (
    .req   (req),
    .last  (last),
    .fixed (FIXED_PRIO != 0),
    .gnt   (pick)
  );

  assign sel   = grant_q[1];
  assign in_ra = (state == RA);
  assign in_rd = (state == RD);
  assign in_wa = (state == WA);
  assign in_wb = (state == WB);

  // Slave-side muxes steered only by the registered grant, so no m*valid reaches s_* while IDLE.
  assign s_araddr  = sel ? m1_araddr : m0_araddr;
  assign s_arvalid = in_ra & (sel ? m1_arvalid : m0_arvalid);
  assign s_rready  = in_rd & (sel ? m1_rready : m0_rready);
  assign s_awaddr  = sel ? m1_awaddr : m0_awaddr;
  assign s_awvalid = in_wa & ~aw_done & (sel ? m1_awvalid : m0_awvalid);
  assign s_wdata   = sel ? m1_wdata : m0_wdata;
  assign s_wstrb   = sel ? m1_wstrb : m0_wstrb;
  assign s_wvalid  = in_wa & ~w_done & (sel ? m1_wvalid : m0_wvalid);
  assign s_bready  = in_wb & (sel ? m1_bready : m0_bready);

  assign m0_arready = in_ra & grant_q[0] & s_arready;
  assign m1_arready = in_ra & grant_q[1] & s_arready;
  assign m0_rvalid  = in_rd & grant_q[0] & s_rvalid;
  assign m1_rvalid  = in_rd & grant_q[1] & s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m1_rresp   = s_rresp;
  assign m0_awready = in_wa & grant_q[0] & ~aw_done & s_awready;
  assign m1_awready = in_wa & grant_q[1] & ~aw_done & s_awready;
  assign m0_wready  = in_wa & grant_q[0] & ~w_done & s_wready;
  assign m1_wready  = in_wa & grant_q[1] & ~w_done & s_wready;
  assign m0_bvalid  = in_wb & grant_q[0] & s_bvalid;
  assign m1_bvalid  = in_wb & grant_q[1] & s_bvalid;
  assign m0_bresp   = s_bresp;
  assign m1_bresp   = s_bresp;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign grant = grant_q;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant_q <= pick;
            // A master presenting both AR and AW has its write served first.
            state   <= (pick[1] ? m1_awvalid : m0_awvalid) ? WA : RA;
          end
        end
        RA: if (s_arvalid && s_arready) state <= RD;
        RD: begin
          if (s_rvalid && s_rready) begin
            state   <= IDLE;
            last    <= sel;
            grant_q <= '0;
          end
        end
        WA: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WB;
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WB: begin
          if (s_bvalid && s_bready) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            last    <= sel;
            grant_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter2.sv
// Directed bench for axi_lite_arbiter2: round-robin instance plus a fixed-priority twin.
module tb_axi_lite_arbiter2;
  import axi_lite_arbiter2_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_arvalid, m0_rready, m0_awvalid, m0_wvalid, m0_bready;
  logic        m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;

  logic        m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid;
  logic        m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [1:0]  grant;
  logic        busy;

  logic        f_m0_arready, f_m0_rvalid, f_m0_awready, f_m0_wready, f_m0_bvalid;
  logic        f_m1_arready, f_m1_rvalid, f_m1_awready, f_m1_wready, f_m1_bvalid;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic [1:0]  f_m0_rresp, f_m1_rresp, f_m0_bresp, f_m1_bresp;
  logic [31:0] f_s_araddr, f_s_awaddr, f_s_wdata;
  logic [3:0]  f_s_wstrb;
  logic        f_s_arvalid, f_s_rready, f_s_awvalid, f_s_wvalid, f_s_bready;
  logic [1:0]  f_grant;
  logic        f_busy;

  logic [14:0]  hs_all;
  logic [189:0] fp_all;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  assign hs_all = {m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid,
                   m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
                   s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
  assign fp_all = {f_m0_arready, f_m0_rdata, f_m0_rresp, f_m0_rvalid, f_m0_awready, f_m0_wready,
                   f_m0_bresp, f_m0_bvalid, f_m1_arready, f_m1_rdata, f_m1_rresp, f_m1_rvalid,
                   f_m1_awready, f_m1_wready, f_m1_bresp, f_m1_bvalid, f_s_araddr, f_s_arvalid,
                   f_s_rready, f_s_awaddr, f_s_awvalid, f_s_wdata, f_s_wstrb, f_s_wvalid,
                   f_s_bready, f_grant, f_busy};

  always #5 clk = ~clk;

  axi_lite_arbiter2 #(.FIXED_PRIO(0), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .busy(busy)
  );

  axi_lite_arbiter2 #(.FIXED_PRIO(1), .AW(32), .DW(32)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready),
    .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(f_m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(f_m0_wready),
    .m0_bresp(f_m0_bresp), .m0_bvalid(f_m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready),
    .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(f_m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(f_m1_wready),
    .m1_bresp(f_m1_bresp), .m1_bvalid(f_m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(f_s_araddr), .s_arvalid(f_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(f_s_rready),
    .s_awaddr(f_s_awaddr), .s_awvalid(f_s_awvalid), .s_awready(s_awready),
    .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wvalid(f_s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(f_s_bready),
    .grant(f_grant), .busy(f_busy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 0; m0_awaddr = '0; m0_awvalid = 0;
    m0_wdata = '0; m0_wstrb = '0; m0_wvalid = 0; m0_bready = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 0; m1_awaddr = '0; m1_awvalid = 0;
    m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_exp [4];
    int aw_k [3];
    int w_k [3];
    int last_k;
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    aw_k   = '{2, 0, 1};
    w_k    = '{0, 2, 1};

    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_handshakes", hs_all, 0);
    check("rst_fp_outputs", fp_all, 0);
    rst = 1'b0;
    tick();

    // T1: single m0 read, data after 3 cycles
    m0_araddr = 32'h8000_0000; m0_arvalid = 1; m0_rready = 1;
    #1 check("t1_idle_no_s_arvalid", s_arvalid, 0);
    tick();
    check("t1_grant", grant, 2'b01);
    check("t1_s_arvalid", s_arvalid, 1);
    check("t1_s_araddr", s_araddr, 32'h8000_0000);
    s_arready = 1;
    #1 check("t1_arready_m1m0", {m1_arready, m0_arready}, 2'b01);
    tick();
    m0_arvalid = 0; s_arready = 0;
    #1 check("t1_rd_wait_rvalid", m0_rvalid, 0);
    check("t1_rd_busy", busy, 1);
    tick();
    tick();
    s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = RESP_OKAY;
    #1 check("t1_m0_rvalid", m0_rvalid, 1);
    check("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("t1_m0_rresp", m0_rresp, RESP_OKAY);
    check("t1_s_rready", s_rready, 1);
    check("t1_m1_untouched", {m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 0);
    tick();
    s_rvalid = 0; m0_rready = 0;
    #1 check("t1_done_busy", busy, 0);
    check("t1_done_grant", grant, 0);

    // T2: simultaneous m0 read and m1 write from reset
    rst = 1; #1 rst = 0;
    m0_araddr = 32'h8000_0004; m0_arvalid = 1; m0_rready = 1;
    m1_awaddr = 32'h8000_0010; m1_awvalid = 1; m1_wdata = 32'h1234_5678;
    m1_wstrb = 4'hF; m1_wvalid = 1; m1_bready = 1;
    #1 check("t2_idle_no_valid", {s_arvalid, s_awvalid, s_wvalid}, 0);
    tick();
    check("t2_first_grant", grant, 2'b01);
    check("t2_m1_blocked", {m1_awready, m1_wready, s_awvalid, s_wvalid}, 0);
    s_arready = 1;
    #1 check("t2_m0_arready", m0_arready, 1);
    tick();
    m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h0BAD_F00D;
    #1 check("t2_rvalid_m1m0", {m1_rvalid, m0_rvalid}, 2'b01);
    tick();
    s_rvalid = 0; m0_rready = 0;
    #1 check("t2_idle_gap_grant", grant, 0);
    tick();
    check("t2_second_grant", grant, 2'b10);
    check("t2_s_aw_w_valid", {s_awvalid, s_wvalid}, 2'b11);
    check("t2_s_awaddr", s_awaddr, 32'h8000_0010);
    check("t2_s_wdata", s_wdata, 32'h1234_5678);
    check("t2_s_wstrb", s_wstrb, 4'hF);
    s_awready = 1; s_wready = 1;
    #1 check("t2_w_readies", {m1_awready, m1_wready, m0_awready, m0_wready}, 4'b1100);
    tick();
    m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = RESP_OKAY;
    #1 check("t2_bvalid_m1m0", {m1_bvalid, m0_bvalid}, 2'b10);
    check("t2_m1_bresp", m1_bresp, RESP_OKAY);
    check("t2_s_bready", s_bready, 1);
    tick();
    s_bvalid = 0; m1_bready = 0;
    #1 check("t2_done_busy", busy, 0);

    // T3: both masters read continuously; RR alternates, fixed priority keeps m1
    rst = 1; #1 rst = 0;
    m0_arvalid = 1; m1_arvalid = 1; m0_rready = 1; m1_rready = 1;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_rr_grant", grant, rr_exp[i]);
      check("t3_rr_arready", {m1_arready, m0_arready}, rr_exp[i]);
      check("t3_fp_grant", f_grant, 2'b10);
      tick();
      tick();
    end
    clear_inputs();
    tick();
    check("t3_idle_both", {busy, f_busy}, 0);

    // T4: W before AW, AW before W, both together
    for (int m = 0; m < 3; m++) begin
      m0_awaddr = 32'h8000_0100; m0_awvalid = 1; m0_wdata = 32'hA5A5_0000;
      m0_wstrb = 4'h3; m0_wvalid = 1; m0_bready = 1;
      tick();
      check("t4_grant", grant, 2'b01);
      last_k = (aw_k[m] > w_k[m]) ? aw_k[m] : w_k[m];
      for (int k = 0; k <= last_k; k++) begin
        s_awready = (k == aw_k[m]); s_wready = (k == w_k[m]);
        #1 check("t4_s_awvalid", s_awvalid, (k <= aw_k[m]));
        check("t4_s_wvalid", s_wvalid, (k <= w_k[m]));
        check("t4_m0_awready", m0_awready, (k == aw_k[m]));
        check("t4_m0_wready", m0_wready, (k == w_k[m]));
        check("t4_no_early_wb", s_bready, 0);
        tick();
      end
      s_awready = 1; s_wready = 1;
      #1 check("t4_wb_no_dup", {s_awvalid, s_wvalid, m0_awready, m0_wready}, 0);
      check("t4_wb_entered", s_bready, 1);
      tick();
      s_bvalid = 1; s_bresp = RESP_EXOKAY;
      #1 check("t4_m0_bvalid", m0_bvalid, 1);
      check("t4_m0_bresp", m0_bresp, RESP_EXOKAY);
      tick();
      clear_inputs();
      #1 check("t4_done_busy", busy, 0);
    end

    // T5: reset while waiting in RD, then a clean m1 read
    m0_araddr = 32'h8000_0200; m0_arvalid = 1; m0_rready = 1;
    tick();
    s_arready = 1;
    tick();
    m0_arvalid = 0; s_arready = 0;
    #1 check("t5_in_rd", {busy, s_rready, m0_rvalid}, 3'b110);
    rst = 1;
    #1 check("t5_rst_busy", busy, 0);
    check("t5_rst_grant", grant, 0);
    check("t5_rst_handshakes", hs_all, 0);
    tick();
    rst = 0; m0_rready = 0;
    m1_araddr = 32'h8000_0020; m1_arvalid = 1; m1_rready = 1;
    tick();
    check("t5_grant", grant, 2'b10);
    s_arready = 1;
    #1 check("t5_arready_m1m0", {m1_arready, m0_arready}, 2'b10);
    tick();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'hCAFE_0001; s_rresp = RESP_SLVERR;
    #1 check("t5_rvalid_m1m0", {m1_rvalid, m0_rvalid}, 2'b10);
    check("t5_m1_rdata", m1_rdata, 32'hCAFE_0001);
    check("t5_m1_rresp", m1_rresp, RESP_SLVERR);
    check("t5_m0_rdata_fanout", m0_rdata, 32'hCAFE_0001);
    tick();
    s_rvalid = 0; m1_rready = 0;
    #1 check("t5_done_busy", busy, 0);

    // T6: m1 stalls R for 5 cycles
    m1_araddr = 32'h8000_0030; m1_arvalid = 1; m1_rready = 0;
    tick();
    s_arready = 1;
    tick();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h600D_D00D; s_rresp = RESP_DECERR;
    for (int j = 0; j < 5; j++) begin
      #1 check("t6_stall_s_rready", s_rready, 0);
      check("t6_stall_m1_rvalid", m1_rvalid, 1);
      check("t6_stall_grant", grant, 2'b10);
      tick();
    end
    m1_rready = 1;
    #1 check("t6_s_rready", s_rready, 1);
    check("t6_m1_rdata", m1_rdata, 32'h600D_D00D);
    check("t6_m1_rresp", m1_rresp, RESP_DECERR);
    tick();
    s_rvalid = 0; m1_rready = 0;
    #1 check("t6_done", {busy, grant}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
